// File: rtl/tape_pkg.sv
// ---------------------------------------------------------------------------
// tape_pkg
// Shared types and constants for the cassette playback encoder.
//   tape_state_t     : sequencer states (IDLE, LEADER, DATA, TAIL)
//   TAPE_FIFO_DEPTH  : entries in the input byte FIFO
//   TAPE_FIFO_WIDTH  : FIFO entry width ({last, data})
//   DEF_*            : default timing for a 12 MHz tick enable
//   cell_level()     : output level for a given bit and half of its cell
// ---------------------------------------------------------------------------
package tape_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEADER = 2'd1,
    DATA   = 2'd2,
    TAIL   = 2'd3
  } tape_state_t;

  localparam int TAPE_FIFO_DEPTH = 4;
  localparam int TAPE_FIFO_WIDTH = 9;

  // 2400 ticks of a 12 MHz enable is a 200 us half-cell
  localparam int DEF_HALF_CELL    = 2400;
  localparam int DEF_LEADER_BYTES = 256;
  localparam int DEF_GAP_HALVES   = 8;

  // Phase encoding: a 1 is high-then-low, a 0 is low-then-high, so the
  // level is simply the bit inverted during the second half of the cell.
  function automatic logic cell_level(input logic bit_val, input logic second_half);
    return bit_val ^ second_half;
  endfunction

endpackage

// File: rtl/tape_fifo.sv
// ---------------------------------------------------------------------------
// tape_fifo
// Synchronous 4 x 9 first-word-fall-through FIFO holding {last, data}.
// Ports:
//   clk_sys  in  : system clock
//   reset_n  in  : synchronous active-low reset
//   push     in  : write wr_data (ignored when full unless popping too)
//   pop      in  : discard the head entry (ignored when empty)
//   flush    in  : empty the FIFO; wins over push and pop
//   wr_data  in  : entry to write
//   rd_data  out : current head entry
//   full     out : no free entry
//   empty    out : no valid entry
// ---------------------------------------------------------------------------
module tape_fifo
  import tape_pkg::*;
(
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [TAPE_FIFO_WIDTH-1:0] wr_data,
  output logic [TAPE_FIFO_WIDTH-1:0] rd_data,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(TAPE_FIFO_DEPTH);

  logic [TAPE_FIFO_WIDTH-1:0] mem [TAPE_FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [PTR_W:0]             count;
  logic                       do_push;
  logic                       do_pop;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // still taken when it coincides with a pop and occupancy stays put.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full    = (count == (PTR_W + 1)'(TAPE_FIFO_DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; depth is a power of two so the
  // pointers wrap naturally.
  always_ff @(posedge clk_sys) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tape_player.sv
// ---------------------------------------------------------------------------
// tape_player
// Cassette playback encoder: serialises a byte stream as phase-encoded tape
// audio, preceded by a leader of 0x00 bytes and followed by a low gap.
// Parameters:
//   HALF_CELL    : ce ticks per half bit cell (2..65535)
//   LEADER_BYTES : 0x00 bytes sent before the first data byte
//   GAP_HALVES   : half-cells of level 0 after the last data bit
// Ports:
//   clk_sys  in  : system clock
//   reset_n  in  : synchronous active-low reset
//   ce       in  : timing tick enable
//   start    in  : begin playback (honoured only when idle)
//   stop     in  : abort playback and flush the FIFO
//   in_valid in  : byte offered
//   in_data  in  : byte value
//   in_last  in  : byte is the final one of the block
//   in_ready out : FIFO has room
//   tape_out out : encoded tape signal (registered)
//   busy     out : not idle
//   done     out : one-cycle pulse at the end of the gap
//   underrun out : sticky, FIFO ran dry at a data byte boundary
// ---------------------------------------------------------------------------
module tape_player
  import tape_pkg::*;
#(
  parameter int HALF_CELL    = DEF_HALF_CELL,
  parameter int LEADER_BYTES = DEF_LEADER_BYTES,
  parameter int GAP_HALVES   = DEF_GAP_HALVES
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       start,
  input  logic       stop,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       tape_out,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  tape_state_t state;
  logic [15:0] half_cnt;
  logic        second_half;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        cur_last;
  logic [31:0] leader_left;
  logic [31:0] gap_left;

  logic [TAPE_FIFO_WIDTH-1:0] fifo_rd_data;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       fifo_push;

  logic half_end;
  logic byte_end;
  logic leader_more;
  logic block_end;
  logic fetch;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;
  assign busy      = (state != IDLE);

  tape_fifo u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fetch),
    .flush   (stop),
    .wr_data ({in_last, in_data}),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Timing and boundary decode. fetch marks the edge on which the next data
  // byte begins, which is also the FIFO pop; with no leader configured that
  // is the start edge itself.
  always_comb begin
    half_end    = ce && (half_cnt == 16'(HALF_CELL - 1));
    byte_end    = ((state == LEADER) || (state == DATA)) && half_end &&
                  second_half && (bit_cnt == 3'd0);
    leader_more = (state == LEADER) && (leader_left != 32'd0);
    block_end   = (state == DATA) && cur_last;
    fetch       = 1'b0;
    if (!stop) begin
      if ((state == IDLE) && start && (LEADER_BYTES == 0)) begin
        fetch = 1'b1;
      end else if (byte_end && !leader_more && !block_end) begin
        fetch = 1'b1;
      end
    end
  end

  // Sequencer, shifter and counters. stop overrides everything; a fetch
  // decided above overrides whatever the state case wrote for that edge.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state       <= IDLE;
      half_cnt    <= '0;
      second_half <= 1'b0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      cur_last    <= 1'b0;
      leader_left <= '0;
      gap_left    <= '0;
      tape_out    <= 1'b0;
      done        <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state       <= IDLE;
        tape_out    <= 1'b0;
        half_cnt    <= '0;
        second_half <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              underrun    <= 1'b0;
              half_cnt    <= '0;
              second_half <= 1'b0;
              bit_cnt     <= 3'd7;
              shift_reg   <= 8'h00;
              tape_out    <= 1'b0;
              leader_left <= (LEADER_BYTES > 0) ? 32'(LEADER_BYTES - 1) : 32'd0;
              state       <= LEADER;
            end
          end

          LEADER, DATA: begin
            if (ce) begin
              if (!half_end) begin
                half_cnt <= half_cnt + 16'd1;
              end else begin
                half_cnt <= '0;
                if (!second_half) begin
                  second_half <= 1'b1;
                  tape_out    <= cell_level(shift_reg[7], 1'b1);
                end else if (bit_cnt != 3'd0) begin
                  second_half <= 1'b0;
                  bit_cnt     <= bit_cnt - 3'd1;
                  shift_reg   <= {shift_reg[6:0], 1'b0};
                  tape_out    <= cell_level(shift_reg[6], 1'b0);
                end else if (leader_more) begin
                  leader_left <= leader_left - 32'd1;
                  second_half <= 1'b0;
                  bit_cnt     <= 3'd7;
                  shift_reg   <= 8'h00;
                  tape_out    <= 1'b0;
                end else if (block_end) begin
                  tape_out <= 1'b0;
                  if (GAP_HALVES == 0) begin
                    done  <= 1'b1;
                    state <= IDLE;
                  end else begin
                    gap_left <= 32'(GAP_HALVES - 1);
                    state    <= TAIL;
                  end
                end
              end
            end
          end

          TAIL: begin
            if (ce) begin
              if (!half_end) begin
                half_cnt <= half_cnt + 16'd1;
              end else begin
                half_cnt <= '0;
                if (gap_left == 32'd0) begin
                  done  <= 1'b1;
                  state <= IDLE;
                end else begin
                  gap_left <= gap_left - 32'd1;
                end
              end
            end
          end

          default: state <= IDLE;
        endcase

        if (fetch) begin
          half_cnt <= '0;
          if (fifo_empty) begin
            underrun <= 1'b1;
            tape_out <= 1'b0;
            state    <= IDLE;
          end else begin
            state       <= DATA;
            shift_reg   <= fifo_rd_data[7:0];
            cur_last    <= fifo_rd_data[8];
            bit_cnt     <= 3'd7;
            second_half <= 1'b0;
            tape_out    <= cell_level(fifo_rd_data[7], 1'b0);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tape_player.sv
// ---------------------------------------------------------------------------
// tb_tape_player
// Self-checking bench for tape_player with HALF_CELL=4, LEADER_BYTES=1,
// GAP_HALVES=2. The reference model expands the expected byte list into a
// list of half-cell levels and advances through it by counting ce ticks.
// ---------------------------------------------------------------------------
module tb_tape_player;

  localparam int HALF_CELL    = 4;
  localparam int LEADER_BYTES = 1;
  localparam int GAP_HALVES   = 2;
  localparam int FIFO_DEPTH   = 4;
  localparam int MAX_CYCLES   = 5000;

  logic       clk_sys  = 1'b0;
  logic       reset_n  = 1'b0;
  logic       ce       = 1'b1;
  logic       start    = 1'b0;
  logic       stop     = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_last  = 1'b0;
  logic       in_ready;
  logic       tape_out;
  logic       busy;
  logic       done;
  logic       underrun;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_bytes[$];
  logic       exp_has_last;
  int         ce_phase = 0;

  typedef struct {
    logic       start;
    logic       stop;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       exp_busy;
    logic       exp_ready;
  } vec_t;

  vec_t vecs[15];

  tape_player #(
    .HALF_CELL    (HALF_CELL),
    .LEADER_BYTES (LEADER_BYTES),
    .GAP_HALVES   (GAP_HALVES)
  ) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ce       (ce),
    .start    (start),
    .stop     (stop),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .tape_out (tape_out),
    .busy     (busy),
    .done     (done),
    .underrun (underrun)
  );

  always #5 clk_sys = ~clk_sys;

  // Hard stop in case something wedges beyond every local bound.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Mode 0: ce always high; 1: one tick in eight; 2: random.
  task automatic setCe(input int mode);
    ce_phase++;
    case (mode)
      1:       ce = ((ce_phase % 8) == 0);
      2:       ce = 1'($urandom_range(0, 1));
      default: ce = 1'b1;
    endcase
  endtask

  task automatic pushByte(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    start    = v.start;
    stop     = v.stop;
    in_valid = v.valid;
    in_data  = v.data;
    in_last  = v.last;
    tick();
    start    = 1'b0;
    stop     = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput($sformatf("vec%0d_busy", idx), busy, v.exp_busy);
    checkOutput($sformatf("vec%0d_in_ready", idx), in_ready, v.exp_ready);
  endtask

  // Starts playback and follows it to done or underrun, comparing every
  // cycle against the half-cell list built from exp_bytes.
  task automatic runPlayback(input int mode);
    logic halves[$];
    int   n, total_halves, h, ticks, cyc, popped;
    logic finished, ce_at_edge;
    n = exp_bytes.size();
    total_halves = 16 * (LEADER_BYTES + n);
    halves.delete();
    for (int i = 0; i < LEADER_BYTES * 8; i++) begin
      halves.push_back(1'b0);
      halves.push_back(1'b1);
    end
    for (int k = 0; k < n; k++) begin
      for (int b = 7; b >= 0; b--) begin
        halves.push_back(exp_bytes[k][b]);
        halves.push_back(!exp_bytes[k][b]);
      end
    end
    start = 1'b1;
    setCe(mode);
    tick();
    start = 1'b0;
    h = 0; ticks = 0; cyc = 0; finished = 1'b0;
    while (!finished && cyc < MAX_CYCLES) begin
      if (h < total_halves) begin
        checkOutput($sformatf("tape_out_h%0d", h), tape_out, halves[h]);
        checkOutput("busy_active", busy, 1'b1);
        checkOutput("done_active", done, 1'b0);
        popped = (h >= 16 * LEADER_BYTES) ? (h - 16 * LEADER_BYTES) / 16 + 1 : 0;
        checkOutput("in_ready_active", in_ready, (n - popped) < FIFO_DEPTH);
        if (h == 0) checkOutput("underrun_cleared", underrun, 1'b0);
      end else if (exp_has_last && h < total_halves + GAP_HALVES) begin
        checkOutput("tape_out_gap", tape_out, 1'b0);
        checkOutput("busy_gap", busy, 1'b1);
        checkOutput("done_gap", done, 1'b0);
      end else begin
        checkOutput("tape_out_end", tape_out, 1'b0);
        checkOutput("busy_end", busy, 1'b0);
        checkOutput("done_end", done, exp_has_last);
        checkOutput("underrun_end", underrun, !exp_has_last);
        finished = 1'b1;
      end
      if (!finished) begin
        setCe(mode);
        ce_at_edge = ce;
        tick();
        cyc++;
        if (ce_at_edge) begin
          ticks++;
          if (ticks == HALF_CELL) begin
            ticks = 0;
            h++;
          end
        end
      end
    end
    if (!finished) begin
      total++;
      bad++;
      $display("[TB] FAIL playback_timeout: got no end after %0d cycles, required end at half %0d", cyc, total_halves);
    end
    ce = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("done_quiet_after", done, 1'b0);
      checkOutput("busy_quiet_after", busy, 1'b0);
    end
  endtask

  initial begin
    logic done_seen;
    int   n;

    // {start, stop, valid, data, last, exp_busy, exp_ready}
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 8'hD4, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 8'hE5, 1'b1, 1'b0, 1'b0};

    // Reset values
    reset_n = 1'b0;
    tick();
    tick();
    checkOutput("reset_tape_out", tape_out, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_underrun", underrun, 1'b0);
    checkOutput("reset_in_ready", in_ready, 1'b1);
    reset_n = 1'b1;
    tick();

    // Basic playback of one final byte
    $display("[TB] basic playback");
    pushByte(8'hA5, 1'b1);
    exp_bytes = '{8'hA5};
    exp_has_last = 1'b1;
    runPlayback(0);

    // ce at one tick in eight: each half-cell spans 32 clocks
    $display("[TB] ce gating");
    pushByte(8'h3C, 1'b1);
    exp_bytes = '{8'h3C};
    exp_has_last = 1'b1;
    runPlayback(1);

    // Underrun after a byte without last
    $display("[TB] underrun");
    pushByte(8'h80, 1'b0);
    exp_bytes = '{8'h80};
    exp_has_last = 1'b0;
    runPlayback(0);

    // Full FIFO, stop flush, stop beating push and start
    $display("[TB] table vectors");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(i, vecs[i]);
    end
    exp_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    exp_has_last = 1'b0;
    runPlayback(0);

    // Stop during the third data bit
    $display("[TB] stop mid-byte");
    pushByte(8'hC3, 1'b0);
    pushByte(8'h3C, 1'b0);
    pushByte(8'hF0, 1'b0);
    pushByte(8'h0F, 1'b1);
    checkOutput("stop_fifo_full", in_ready, 1'b0);
    ce = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (85) tick();
    checkOutput("stop_third_bit_level", tape_out, 1'b1);
    checkOutput("stop_busy_before", busy, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("stop_tape_out", tape_out, 1'b0);
    checkOutput("stop_busy", busy, 1'b0);
    checkOutput("stop_in_ready", in_ready, 1'b1);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      done_seen = done_seen | done;
      tick();
    end
    checkOutput("stop_no_done", done_seen, 1'b0);
    exp_bytes.delete();
    exp_has_last = 1'b0;
    runPlayback(0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("underrun_kept_by_stop", underrun, 1'b1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checkOutput("underrun_cleared_by_reset", underrun, 1'b0);

    // Reset during the leader
    $display("[TB] reset mid-leader");
    pushByte(8'h5A, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    checkOutput("rst_busy_before", busy, 1'b1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checkOutput("rst_tape_out", tape_out, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_underrun", underrun, 1'b0);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    exp_bytes.delete();
    exp_has_last = 1'b0;
    runPlayback(0);

    // Randomised blocks
    $display("[TB] random blocks");
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 4);
      exp_has_last = 1'($urandom_range(0, 1));
      exp_bytes.delete();
      for (int i = 0; i < n; i++) begin
        exp_bytes.push_back(8'($urandom_range(0, 255)));
        pushByte(exp_bytes[i], exp_has_last && (i == n - 1));
      end
      runPlayback($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tape_player.md
# tape_player

Cassette playback encoder for the Vector-06C core. It takes a byte stream from the loader side, for example the ioctl download path or an SD image reader. It serialises the bytes as phase-encoded (Manchester) tape audio on `tape_out`, which drives the PPI1 port C `tapein` bit read by the CPU's tape-load routine. It is the transmit end of the tape interface whose receiver is the ROM/CPU software. It contains a leader generator, a small input FIFO, bit timing, and underrun/abort handling.

## Interface
Parameters:
- `HALF_CELL`, 2400: `ce` ticks per half bit cell. 200 µs at the 12 MHz `ce_12mp` rate. Legal range 2..65535.
- `LEADER_BYTES`, 256: number of 0x00 bytes emitted before the first data byte.
- `GAP_HALVES`, 8: half-cells of level 0 emitted after the last data bit.

Ports:
- `clk_sys` in 1: system clock (96 MHz).
- `reset_n` in 1: reset, synchronous and active-low.
- `ce` in 1: timing tick enable, one `clk_sys` wide.
- `start` in 1: begin playback; sampled in IDLE only.
- `stop` in 1: abort playback; accepted in any state.
- `in_valid` in 1: byte offered.
- `in_data` in 8: byte value.
- `in_last` in 1: qualifies `in_data` as the final byte of the block.
- `in_ready` out 1: FIFO not full. A byte is accepted on `in_valid & in_ready`.
- `tape_out` out 1: encoded tape signal.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when TAIL completes.
- `underrun` out 1: sticky. Set when the FIFO is empty at a DATA byte boundary. Cleared by an accepted `start` or by reset.

## Operation
- **FIFO:** 4 entries of 9 bits ({last, data}). Writes are allowed in every state, including IDLE, so the FIFO can be prefilled. A simultaneous push and pop when full is allowed; occupancy is unchanged.
- **States and transitions:**
  - IDLE → LEADER on `start`. If `LEADER_BYTES` = 0, IDLE → DATA instead.
  - LEADER: emit `LEADER_BYTES` bytes of 0x00, then go to DATA.
  - DATA: at each byte boundary, pop one FIFO entry and shift it out MSB first. After the bit-0 cell of an entry marked last, go to TAIL.
  - TAIL: hold `tape_out`=0 for `GAP_HALVES` half-cells, pulse `done`, go to IDLE.
- **Bit encoding:** one cell = two half-cells.
  - Bit 1: first half high, second half low.
  - Bit 0: first half low, second half high.
- **Underrun:** at a DATA byte boundary with the FIFO empty, set `underrun`, drive `tape_out`=0, and go to IDLE. No `done` pulse.
- **Stop:** `stop` wins over every other event in the same cycle, including `start` and a push. Next cycle: state IDLE, FIFO flushed, `tape_out`=0, half-cell counter cleared. `underrun` is unchanged.
- **`start` while busy:** ignored.

## Timing
- **Reset values:** `tape_out`=0, `busy`=0, `done`=0, `underrun`=0, `in_ready`=1, FIFO empty, state IDLE.
- **Start latency:** the cycle after `start` is sampled, state leaves IDLE and `tape_out` drives the first half of the first bit. The half-cell counter restarts at 0.
- **Half-cell advance:** the counter counts `ce` ticks only. When it reaches `HALF_CELL`-1 on a `ce`, the output advances to the next half-cell on the following cycle. Every half-cell is therefore exactly `HALF_CELL` `ce` ticks long.
- **Byte pop:** occurs on the cycle the first half of the byte begins. `in_ready` rises the cycle after the pop if the FIFO was full.
- **Output register:** `tape_out` is registered with no combinational path from the inputs.
- **Stream length:** a block of N data bytes lasts 2·8·(`LEADER_BYTES`+N)+`GAP_HALVES` half-cells from start to the `done` pulse.

## Structure
- Shared package `tape_pkg`:
  - state enum `tape_state_t` (IDLE, LEADER, DATA, TAIL);
  - `TAPE_FIFO_DEPTH`=4;
  - the default timing constants.
- One sub-module: `tape_fifo`, a synchronous 4×9 FIFO with push/pop/flush and full/empty flags.
- The sequencing, shifter, and counters stay in `tape_player`.

## Test plan
All scenarios use `HALF_CELL`=4, `LEADER_BYTES`=1, `GAP_HALVES`=2, with `ce` held high.
- **Basic playback:** prefill 0xA5 (last), then `start`. Required:
  - 8 cells of leader: 01 pattern per cell;
  - then 10 01 10 01 01 10 01 10 over 64 cycles;
  - then 8 cycles low;
  - `done` high for exactly 1 cycle; `busy` falls with it.
- **Underrun:** load 0x80 without last, then `start`. Required:
  - `underrun`=1 after the 0x80 bits;
  - `tape_out`=0, state IDLE;
  - no `done` pulse.
- **Full FIFO:** push 5 bytes back-to-back in IDLE. Required:
  - `in_ready`=0 after the 4th push;
  - the 5th byte is not accepted.
  - After `start`, `in_ready`=1 the cycle after the first data pop.
- **Stop mid-byte:**
  - Assert `stop` during the 3rd data bit. Required next cycle: `tape_out`=0, `busy`=0, FIFO empty, `done` never pulses.
  - Assert `stop` and `start` in the same cycle. Required: `stop` wins and the block stays in IDLE.
- **Reset mid-operation:** drop `reset_n` during LEADER. Required: every output at its reset value the next cycle, including `underrun`=0.
- **`ce` gating:** toggle `ce` at a 1/8 duty cycle. Required: every half-cell is exactly 32 `clk_sys` cycles.
